// File: rtl/peripheral_gpio_debounce.sv
// Per-bit pad synchronizer, debounce filter and edge/interrupt
// generator that feeds the gpio_i port of the GPIO APB4 core.
module peripheral_gpio_debounce #(
    parameter int PDATA_SIZE = 32,
    parameter int SYNC_DEPTH = 3,
    parameter int CNT_SIZE   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [PDATA_SIZE-1:0] gpio_pad_i,
    input  logic [PDATA_SIZE-1:0] cfg_deb_en,
    input  logic [CNT_SIZE-1:0]   cfg_limit,
    input  logic [PDATA_SIZE-1:0] cfg_rise_en,
    input  logic [PDATA_SIZE-1:0] cfg_fall_en,
    input  logic [PDATA_SIZE-1:0] irq_clr,
    output logic [PDATA_SIZE-1:0] gpio_i,
    output logic [PDATA_SIZE-1:0] rise_o,
    output logic [PDATA_SIZE-1:0] fall_o,
    output logic [PDATA_SIZE-1:0] irq_pending,
    output logic                  irq_o
);

    typedef logic [PDATA_SIZE-1:0] vec_t;
    typedef logic [CNT_SIZE-1:0]   cnt_t;

    vec_t [SYNC_DEPTH-1:0] sync_q, sync_d;
    vec_t                  stable_q, stable_d;
    vec_t                  stable_dly_q, stable_dly_d;
    vec_t                  rise_q, rise_d;
    vec_t                  fall_q, fall_d;
    vec_t                  pend_q, pend_d;
    cnt_t [PDATA_SIZE-1:0] cnt_q, cnt_d;
    vec_t                  sync;

    assign sync = sync_q[SYNC_DEPTH-1];

    always_comb begin
        sync_d[0] = gpio_pad_i;
        for (int k = 1; k < SYNC_DEPTH; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Compare before increment, so an all-ones limit never overflows.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < PDATA_SIZE; i++) begin
            if (!cfg_deb_en[i]) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == cfg_limit) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stable_dly_d = stable_q;
        rise_d       = stable_q & ~stable_dly_q;
        fall_d       = ~stable_q & stable_dly_q;
        pend_d       = (pend_q & ~irq_clr)
                     | (rise_q & cfg_rise_en)
                     | (fall_q & cfg_fall_en);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_q       <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            pend_q       <= '0;
            cnt_q        <= '0;
        end else begin
            sync_q       <= sync_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
        end
    end

    assign gpio_i      = stable_q;
    assign rise_o      = rise_q;
    assign fall_o      = fall_q;
    assign irq_pending = pend_q;
    assign irq_o       = |pend_q;

endmodule

// File: tb/tb_peripheral_gpio_debounce.sv
// Directed and randomized checks of the GPIO debounce block
// with SYNC_DEPTH=3 and 32 bits.
module tb_peripheral_gpio_debounce;

    localparam int W  = 32;
    localparam int SD = 3;
    localparam int CW = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic [W-1:0]  gpio_pad_i, cfg_deb_en, cfg_rise_en, cfg_fall_en, irq_clr;
    logic [CW-1:0] cfg_limit;
    logic [W-1:0]  gpio_i, rise_o, fall_o, irq_pending;
    logic          irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    peripheral_gpio_debounce #(
        .PDATA_SIZE(W), .SYNC_DEPTH(SD), .CNT_SIZE(CW)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .gpio_pad_i(gpio_pad_i),
        .cfg_deb_en(cfg_deb_en), .cfg_limit(cfg_limit),
        .cfg_rise_en(cfg_rise_en), .cfg_fall_en(cfg_fall_en),
        .irq_clr(irq_clr), .gpio_i(gpio_i), .rise_o(rise_o),
        .fall_o(fall_o), .irq_pending(irq_pending), .irq_o(irq_o)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        tick(2);
        chk("rst_gpio", gpio_i, 0);
        chk("rst_rise", rise_o, 0);
        chk("rst_fall", fall_o, 0);
        chk("rst_pend", irq_pending, 0);
        chk("rst_irq", {31'b0, irq_o}, 0);
        PRESET = 1'b0;
    endtask

    // Reference model state
    logic [W-1:0]  m_sync [SD];
    logic [W-1:0]  m_st, m_dly, m_rise, m_fall, m_pend;
    logic [CW-1:0] m_cnt [W];

    task automatic model_clear();
        for (int k = 0; k < SD; k++) m_sync[k] = '0;
        for (int i = 0; i < W; i++) m_cnt[i] = '0;
        m_st = '0; m_dly = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] s, nst;
        s   = m_sync[SD-1];
        nst = m_st;
        for (int i = 0; i < W; i++) begin
            if (!cfg_deb_en[i]) begin
                nst[i] = s[i];
                m_cnt[i] = '0;
            end else if (s[i] == m_st[i]) begin
                m_cnt[i] = '0;
            end else if (m_cnt[i] == cfg_limit) begin
                nst[i] = s[i];
                m_cnt[i] = '0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1'b1;
            end
        end
        for (int k = SD-1; k > 0; k--) m_sync[k] = m_sync[k-1];
        m_sync[0] = gpio_pad_i;
        m_pend = (m_pend & ~irq_clr) | (m_rise & cfg_rise_en)
               | (m_fall & cfg_fall_en);
        m_rise = m_st & ~m_dly;
        m_fall = ~m_st & m_dly;
        m_dly  = m_st;
        m_st   = nst;
    endtask

    int seen;

    initial begin
        gpio_pad_i = '0; cfg_deb_en = '0; cfg_rise_en = '0;
        cfg_fall_en = '0; irq_clr = '0; cfg_limit = '0;
        do_reset();

        // Debounced rise, limit 4
        cfg_limit = 4; cfg_deb_en = 32'h1; cfg_rise_en = 32'h1;
        gpio_pad_i = 32'h1;
        tick(7);
        chk("deb_e7_gpio", gpio_i[0], 0);
        tick();
        chk("deb_e8_gpio", gpio_i[0], 1);
        chk("deb_e8_rise", rise_o[0], 0);
        tick();
        chk("deb_e9_rise", rise_o[0], 1);
        chk("deb_e9_pend", irq_pending[0], 0);
        tick();
        chk("deb_e10_rise", rise_o[0], 0);
        chk("deb_e10_pend", irq_pending[0], 1);
        chk("deb_e10_irq", {31'b0, irq_o}, 1);
        irq_clr = 32'h1;
        tick();
        irq_clr = '0;
        chk("deb_clr_pend", irq_pending[0], 0);

        // Glitch shorter than the limit
        gpio_pad_i = '0;
        do_reset();
        gpio_pad_i = 32'h1;
        tick(3);
        gpio_pad_i = '0;
        tick(3);
        chk("gl_cnt3", dut.cnt_q[0], 3);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rise_o[0] || gpio_i[0]) seen++;
        end
        chk("gl_no_change", seen, 0);
        chk("gl_cnt0", dut.cnt_q[0], 0);

        // Bypass ignores a large limit
        cfg_deb_en = '0; cfg_limit = 100;
        gpio_pad_i = 32'h20;
        tick(3);
        chk("byp_e3", gpio_i[5], 0);
        tick();
        chk("byp_e4", gpio_i[5], 1);
        gpio_pad_i = '0;
        tick(4);
        chk("byp_fall_gpio", gpio_i[5], 0);
        tick();
        chk("byp_fall_o", fall_o[5], 1);

        // Fall interrupt with coincident clear
        do_reset();
        cfg_fall_en = 32'h4;
        gpio_pad_i = 32'h4;
        tick(8);
        chk("f2_high", gpio_i[2], 1);
        chk("f2_nopend", irq_pending[2], 0);
        gpio_pad_i = '0;
        tick(5);
        chk("f2_fall", fall_o[2], 1);
        irq_clr = 32'h4;
        tick();
        irq_clr = '0;
        chk("f2_setwins", irq_pending[2], 1);
        chk("f2_irq", {31'b0, irq_o}, 1);
        tick(2);
        chk("f2_hold", irq_pending[2], 1);
        irq_clr = 32'h4;
        tick();
        irq_clr = '0;
        chk("f2_cleared", irq_pending[2], 0);
        chk("f2_irq0", {31'b0, irq_o}, 0);
        cfg_fall_en = '0;

        // Async reset mid-count with all-ones limit
        do_reset();
        cfg_limit = 16'hFFFF; cfg_deb_en = '1;
        gpio_pad_i = 32'h1;
        tick(10);
        chk("ar_cnt_run", dut.cnt_q[0], 7);
        PRESET = 1'b1;
        #1;
        chk("ar_cnt0", dut.cnt_q[0], 0);
        chk("ar_gpio", gpio_i, 0);
        chk("ar_irq", {31'b0, irq_o}, 0);
        gpio_pad_i = '0;
        tick();
        PRESET = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rise_o != 0 || fall_o != 0 || gpio_i != 0) seen++;
        end
        chk("ar_no_spur", seen, 0);

        // Randomized run against the reference model
        do_reset();
        model_clear();
        cfg_limit   = 3;
        cfg_deb_en  = $urandom;
        cfg_rise_en = $urandom;
        cfg_fall_en = $urandom;
        seen = 0;
        for (int c = 0; c < 300; c++) begin
            gpio_pad_i = gpio_pad_i ^ ($urandom & $urandom & $urandom);
            irq_clr = $urandom & $urandom & $urandom;
            @(posedge PCLK);
            model_step();
            #1;
            chk("rnd_gpio", gpio_i, m_st);
            chk("rnd_rise", rise_o, m_rise);
            chk("rnd_fall", fall_o, m_fall);
            chk("rnd_pend", irq_pending, m_pend);
        end
        irq_clr = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
